glitch_burst_gen: RTL and testbench
===================================

Name: glitch_burst_gen

Overview:
Parametrised successor to the single-shot glitch pulser. An external trigger rising edge starts a burst: a programmable delay, then a programmable number of pulses of programmable width, separated by programmable gaps. The block has a toggle (square-wave) pulse mode and an automatic width sweep across triggers. It sits between the target-sync logic and the glitch output driver, and is clocked from the clock-wizard output domain.

Parameters:
DLY_W, 16, width of the delay counter and cfg_delay
WID_W, 8, width of the pulse-width counter, cfg_width, cfg_sweep_step and sweep_cur
GAP_W, 8, width of the inter-pulse gap counter and cfg_gap
REP_W, 4, width of cfg_repeat (pulses per burst = cfg_repeat+1)

Ports:
clk_in  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
arm  in  1  level enable; low aborts any burst and blocks triggers
trigger  in  1  start request; rising edge detected internally
cfg_delay  in  DLY_W  cycles from trigger detection to the first pulse
cfg_width  in  WID_W  pulse width in cycles; in sweep mode, the sweep maximum
cfg_gap  in  GAP_W  low cycles between pulses
cfg_repeat  in  REP_W  extra pulses per burst
cfg_toggle  in  1  1 = square wave inside each pulse
cfg_sweep  in  1  1 = use sweep_cur as the width
cfg_sweep_step  in  WID_W  sweep increment per burst
glitch_out  out  1  registered glitch drive
busy  out  1  high while a burst is in progress
done  out  1  one-cycle pulse at burst completion
sweep_cur  out  WID_W  current sweep width
sweep_wrap  out  1  toggles each time the sweep wraps

Behaviour:
- Reset: glitch_out=0, busy=0, done=0, sweep_cur=0, sweep_wrap=0, state=IDLE, trigger edge register=0.
- Edge detect: trig_d <= trigger every cycle, unconditionally. An edge at cycle N means trigger=1 and trig_d=0 at posedge N.
- An edge is accepted only in IDLE with arm=1. Edges arriving while busy, in DONE, or with arm=0 are dropped, not queued.
- On acceptance, all cfg_* are latched. Width used W = cfg_sweep ? sweep_cur : cfg_width. Later cfg changes do not affect the running burst.
- FSM states:
  - IDLE -> DELAY on an accepted edge. If cfg_delay=0, go straight to PULSE; if W=0, go straight to DONE.
  - DELAY: counts cfg_delay cycles, then -> PULSE (or -> DONE if W=0).
  - PULSE: counts W cycles. Then -> GAP if pulses remain and cfg_gap>0; -> PULSE if pulses remain and cfg_gap=0; otherwise -> DONE.
  - GAP: counts cfg_gap cycles, then -> PULSE.
  - DONE: lasts exactly one cycle, then -> IDLE.
- Output timing:
  - glitch_out is registered.
  - For an edge at posedge N, the first pulse occupies cycles N+1+D .. N+D+W.
  - Each later pulse starts W+G cycles after the previous one.
  - No gap is inserted after the last pulse.
- Toggle mode: inside each pulse, glitch_out = 1,0,1,0,... with phase restarting at 1 for every pulse. Otherwise glitch_out=1 for the whole pulse. glitch_out=0 in IDLE, DELAY, GAP and DONE.
- busy = (state != IDLE), registered, so it is high from N+1 through the DONE cycle inclusive.
- done = 1 only in the DONE cycle.
- W=0: no pulses and no gaps; DONE follows the delay. done is high at N+1+D.
- Sweep, evaluated in the DONE cycle when the latched cfg_sweep=1:
  - If sweep_cur + cfg_sweep_step (computed WID_W+1 bits wide) > cfg_width: sweep_cur <= 0 and sweep_wrap toggles.
  - Otherwise sweep_cur <= sum.
  - Step 0 holds the width.
  - cfg_sweep=0 in IDLE clears sweep_cur to 0.
- Abort: arm=0 in any non-IDLE state gives state=IDLE, glitch_out=0, busy=0 at the next edge. There is no done pulse and sweep_cur is unchanged.
- Reset mid-burst: identical to the reset state at the next edge.
- All counters saturate-free. Widths are exactly as parameterised and no counter wraps within a legal configuration.

Test Plan:
- D=3, W=2, R=0, no toggle; trigger edge at N -> glitch_out=1 at N+4,N+5; done=1 at N+6; busy high N+1..N+6.
- D=0, W=2, G=3, R=2 -> glitch_out high at N+1-2, N+6-7, N+11-12; done at N+13; a second trigger edge at N+5 is ignored.
- Toggle on, D=1, W=5, G=0, R=1 -> glitch_out 1,0,1,0,1,1,0,1,0,1 over N+2..N+11; done at N+12.
- Sweep on, cfg_width=4, step=2, D=0, R=0; four bursts -> widths 0,2,4,0; the first burst has done at N+1 with no high cycles; sweep_wrap toggles once after the third burst.
- Drop arm at the second high cycle of a W=6 pulse -> glitch_out=0 and busy=0 at the next edge; no done; a new edge after arm returns high starts a fresh burst.
- Hold trigger high across two bursts, and assert reset mid-DELAY -> only one burst fires; after reset, all outputs are 0 and sweep_cur=0.

Source files
------------

// File: rtl/glitch_burst_gen.sv
// glitch_burst_gen: trigger-started burst (delay, N pulses of width W, gaps) with toggle mode and width sweep; ins clk_in/reset/arm/trigger/cfg_*, outs glitch_out/busy/done/sweep_cur/sweep_wrap
module glitch_burst_gen #(
  parameter int DLY_W = 16,
  parameter int WID_W = 8,
  parameter int GAP_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             arm,
  input  logic             trigger,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             cfg_toggle,
  input  logic             cfg_sweep,
  input  logic [WID_W-1:0] cfg_sweep_step,
  output logic             glitch_out,
  output logic             busy,
  output logic             done,
  output logic [WID_W-1:0] sweep_cur,
  output logic             sweep_wrap
);
  localparam int CW = DLY_W > WID_W ? (DLY_W > GAP_W ? DLY_W : GAP_W) : (WID_W > GAP_W ? WID_W : GAP_W);
  typedef enum logic [2:0] {IDLE, DELAY, PULSE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic trig_q, trig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [WID_W-1:0] wid_q, wid_d, step_q, step_d, max_q, max_d, sweep_q, sweep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic tog_q, tog_d, swp_q, swp_d, wrap_q, wrap_d;
  logic glitch_q, glitch_d, busy_q, busy_d, done_q, done_d;
  logic abort, last, over;
  logic [CW-1:0] len;
  logic [WID_W-1:0] w_sel;
  logic [WID_W:0] sum;
  always_comb begin
    trig_d = trigger;
    state_d = state_q;
    cnt_d = cnt_q;
    dly_d = dly_q;
    wid_d = wid_q;
    gap_d = gap_q;
    rep_d = rep_q;
    tog_d = tog_q;
    swp_d = swp_q;
    step_d = step_q;
    max_d = max_q;
    sweep_d = sweep_q;
    wrap_d = wrap_q;
    abort = !arm && state_q != IDLE;
    w_sel = cfg_sweep ? sweep_q : cfg_width;
    len = state_q == DELAY ? CW'(dly_q) : state_q == PULSE ? CW'(wid_q) : CW'(gap_q);
    last = cnt_q + CW'(1) == len;
    sum = {1'b0, sweep_q} + {1'b0, step_q};
    over = sum > {1'b0, max_q};
    case (state_q)
      IDLE: begin
        if (!cfg_sweep) sweep_d = '0;
        if (trigger && !trig_q && arm) begin
          dly_d = cfg_delay;
          wid_d = w_sel;
          gap_d = cfg_gap;
          rep_d = cfg_repeat;
          tog_d = cfg_toggle;
          swp_d = cfg_sweep;
          step_d = cfg_sweep_step;
          max_d = cfg_width;
          cnt_d = '0;
          state_d = cfg_delay != '0 ? DELAY : w_sel != '0 ? PULSE : DONE;
        end
      end
      DELAY: begin
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) state_d = wid_q != '0 ? PULSE : DONE;
      end
      PULSE: begin
        // counter restarts per pulse so its LSB gives the toggle phase
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          state_d = rep_q == '0 ? DONE : gap_q != '0 ? GAP : PULSE;
          rep_d = rep_q == '0 ? rep_q : rep_q - REP_W'(1);
        end
      end
      GAP: begin
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) state_d = PULSE;
      end
      DONE: begin
        state_d = IDLE;
        if (swp_q) begin
          sweep_d = over ? '0 : sum[WID_W-1:0];
          wrap_d = wrap_q ^ over;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      sweep_d = sweep_q;
      wrap_d = wrap_q;
    end
    glitch_d = !abort && state_q == PULSE && (!tog_q || !cnt_q[0]);
    busy_d = !abort && state_q != IDLE;
    done_d = !abort && state_q == DONE;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      cnt_q <= '0;
      dly_q <= '0;
      wid_q <= '0;
      gap_q <= '0;
      rep_q <= '0;
      tog_q <= 1'b0;
      swp_q <= 1'b0;
      step_q <= '0;
      max_q <= '0;
      sweep_q <= '0;
      wrap_q <= 1'b0;
      glitch_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q <= trig_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
      wid_q <= wid_d;
      gap_q <= gap_d;
      rep_q <= rep_d;
      tog_q <= tog_d;
      swp_q <= swp_d;
      step_q <= step_d;
      max_q <= max_d;
      sweep_q <= sweep_d;
      wrap_q <= wrap_d;
      glitch_q <= glitch_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign glitch_out = glitch_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sweep_cur = sweep_q;
  assign sweep_wrap = wrap_q;
endmodule

// File: tb/tb_glitch_burst_gen.sv
// tb_glitch_burst_gen: directed plus random bursts checked against a timeline model of glitch_burst_gen
module tb_glitch_burst_gen;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0;
  logic trigger = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [7:0] cfg_width = '0;
  logic [7:0] cfg_gap = '0;
  logic [3:0] cfg_repeat = '0;
  logic cfg_toggle = 1'b0;
  logic cfg_sweep = 1'b0;
  logic [7:0] cfg_sweep_step = '0;
  logic glitch_out, busy, done, sweep_wrap;
  logic [7:0] sweep_cur;
  glitch_burst_gen dut (
    .clk_in(clk_in), .reset(reset), .arm(arm), .trigger(trigger),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .cfg_toggle(cfg_toggle), .cfg_sweep(cfg_sweep), .cfg_sweep_step(cfg_sweep_step),
    .glitch_out(glitch_out), .busy(busy), .done(done), .sweep_cur(sweep_cur), .sweep_wrap(sweep_wrap)
  );
  always #5 clk_in = ~clk_in;
  int total = 0, fails = 0, cyc = 0;
  int act = 0, n = 0, dc = -1, span = 0, prev_trig = 0, m_sweep = 0, m_wrap = 0;
  int l_d = 0, l_w = 0, l_g = 0, l_r = 0, l_tog = 0, l_swp = 0, l_step = 0, l_max = 0;
  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  // one clock: update the timeline model from the inputs seen at the edge, then compare mid-cycle
  task automatic step();
    int off, per, eg, eb, ed;
    bit edge_seen, inb;
    @(posedge clk_in);
    cyc++;
    if (reset) begin
      act = 0;
      m_sweep = 0;
      m_wrap = 0;
      prev_trig = 0;
    end else begin
      edge_seen = trigger && !prev_trig;
      inb = act != 0 && cyc <= dc;
      if (inb && !arm) act = 0;
      else if (inb) begin
        if (cyc == dc && l_swp != 0) begin
          if (m_sweep + l_step > l_max) begin
            m_sweep = 0;
            m_wrap ^= 1;
          end else m_sweep = m_sweep + l_step;
        end
      end else begin
        if (!cfg_sweep) m_sweep = 0;
        if (edge_seen && arm) begin
          n = cyc;
          l_d = int'(cfg_delay);
          l_w = cfg_sweep ? m_sweep : int'(cfg_width);
          l_g = int'(cfg_gap);
          l_r = int'(cfg_repeat);
          l_tog = int'(cfg_toggle);
          l_swp = int'(cfg_sweep);
          l_step = int'(cfg_sweep_step);
          l_max = int'(cfg_width);
          span = l_w == 0 ? 0 : (l_r + 1) * l_w + l_r * l_g;
          dc = n + 1 + l_d + span;
          act = 1;
        end
      end
      prev_trig = int'(trigger);
    end
    eb = int'(act != 0 && cyc > n && cyc <= dc);
    ed = int'(act != 0 && cyc == dc);
    off = cyc - (n + 1 + l_d);
    per = l_w + l_g == 0 ? 1 : l_w + l_g;
    eg = int'(act != 0 && l_w != 0 && off >= 0 && off < span && (off % per) < l_w && (l_tog == 0 || (off % per) % 2 == 0));
    @(negedge clk_in);
    chk("glitch_out", int'(glitch_out), eg);
    chk("busy", int'(busy), eb);
    chk("done", int'(done), ed);
    chk("sweep_cur", int'(sweep_cur), m_sweep);
    chk("sweep_wrap", int'(sweep_wrap), m_wrap);
  endtask
  task automatic run(int k);
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic cfg(int d, int w, int g, int r, int tog, int swp, int st);
    cfg_delay = 16'(d);
    cfg_width = 8'(w);
    cfg_gap = 8'(g);
    cfg_repeat = 4'(r);
    cfg_toggle = tog[0];
    cfg_sweep = swp[0];
    cfg_sweep_step = 8'(st);
  endtask
  task automatic fire();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask
  initial begin
    run(3);
    reset = 1'b0;
    arm = 1'b1;
    run(2);
    cfg(3, 2, 0, 0, 0, 0, 0);
    fire();
    run(10);
    cfg(0, 2, 3, 2, 0, 0, 0);
    fire();
    run(3);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    run(12);
    cfg(1, 5, 0, 1, 1, 0, 0);
    fire();
    run(15);
    cfg(0, 4, 0, 0, 0, 1, 2);
    for (int b = 0; b < 4; b++) begin
      fire();
      run(8);
    end
    chk("wrap_after_sweep", int'(sweep_wrap), 1);
    cfg(2, 6, 0, 0, 0, 0, 0);
    fire();
    run(4);
    arm = 1'b0;
    run(4);
    arm = 1'b1;
    fire();
    run(15);
    cfg(2, 2, 1, 0, 0, 0, 0);
    trigger = 1'b1;
    run(20);
    trigger = 1'b0;
    run(2);
    cfg(5, 3, 0, 0, 0, 0, 0);
    fire();
    run(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("busy_after_reset", int'(busy), 0);
    run(5);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0)
        cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) trigger = ~trigger;
      arm = $urandom_range(0, 39) != 0;
      reset = $urandom_range(0, 499) == 0;
      step();
    end
    reset = 1'b0;
    run(3);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
